// File: rtl/param_word_serializer.sv
// Word serializer: accepts a DATA_W-bit word over valid/ready and shifts it out one bit per
// fast_clk_in cycle, with a word-framing slow clock, optional idle gap, done pulse and word counter.
module param_word_serializer #(
  parameter int DATA_W     = 24,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic              fast_clk_in,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              serial_out,
  output logic              slow_clk_out,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [1:0]        fsm_state
);

  // Handshake: a word transfers on a rising edge where data_valid and data_ready are both high;
  // data_ready never depends on data_valid, and data_in is sampled only on that edge.

  localparam int IDX_W = $clog2(DATA_W);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int HALF  = (DATA_W + 1) / 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(HALF);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              serial_nxt, slow_nxt, done_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              last_bit, accept;

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  // The shift register is kept one bit ahead of serial_out, so its head is always the next bit.
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign last_bit   = (state == SHIFT) && (bit_idx == LAST_IDX);
  assign data_ready = (state == IDLE) || (last_bit && (GAP_CYCLES == 0));
  assign accept     = data_valid && data_ready;
  assign busy       = (state != IDLE);
  assign fsm_state  = state;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    gap_cnt_nxt = gap_cnt;
    serial_nxt  = serial_out;
    slow_nxt    = slow_clk_out;
    done_nxt    = 1'b0;
    cnt_nxt     = word_cnt;
    case (state)
      IDLE: begin
        serial_nxt = 1'b0;
        slow_nxt   = 1'b0;
      end
      SHIFT: begin
        if (!last_bit) begin
          bit_idx_nxt = bit_idx + IDX_W'(1);
          serial_nxt  = head_bit(shreg);
          shreg_nxt   = advance(shreg);
          slow_nxt    = (bit_idx_nxt < HALF_IDX);
        end else begin
          done_nxt   = 1'b1;
          cnt_nxt    = word_cnt + CNT_W'(1);
          serial_nxt = 1'b0;
          slow_nxt   = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_nxt   = GAP;
            gap_cnt_nxt = '0;
          end else if (!accept) begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == LAST_GAP) state_nxt = IDLE;
        else                     gap_cnt_nxt = gap_cnt + GAP_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    // Loading overrides the above: accept is only possible in IDLE or on a back-to-back last bit.
    if (accept) begin
      state_nxt   = SHIFT;
      shreg_nxt   = advance(data_in);
      serial_nxt  = head_bit(data_in);
      slow_nxt    = 1'b1;
      bit_idx_nxt = '0;
    end
  end

  always_ff @(posedge fast_clk_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_idx      <= '0;
      gap_cnt      <= '0;
      serial_out   <= 1'b0;
      slow_clk_out <= 1'b0;
      done         <= 1'b0;
      word_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      bit_idx      <= bit_idx_nxt;
      gap_cnt      <= gap_cnt_nxt;
      serial_out   <= serial_nxt;
      slow_clk_out <= slow_nxt;
      done         <= done_nxt;
      word_cnt     <= cnt_nxt;
    end
  end

endmodule
